// File: rtl/vec_mul_seq.sv
// -----------------------------------------------------------------------------
// vec_mul_seq
//
// Sequencer and result-path controller for the vector-multiply engine.
// A job optionally pops one weight set from the weight FIFO and strobes the
// array's weight_reload. It then streams vec_count unified-buffer vectors,
// starting at vec_base, through the PE array, one per cycle. Each array result
// is written to the result SRAM, starting at res_base. Both address counters
// wrap modulo 2^ADDRESSSIZE.
//
// Optional build macro: VEC_MUL_SEQ_RELU_EN
//   defined   -> every signed lane of res_data is clamped to 0 when negative
//   undefined -> res_data is psum_in passed through unchanged
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   start              launch a job (only honoured in IDLE)
//   abort              cancel the current job (highest priority)
//   load_weights       with start: do a weight pop/latch before streaming
//   vec_base/res_base  first UB / result address, sampled with start
//   vec_count          number of vectors (0..2^ADDRESSSIZE), sampled with start
//   fifo_empty         weight FIFO empty flag
//   fifo_read_enable   weight FIFO pop strobe
//   weight_reload      array weight latch strobe
//   ub_rd_en, ub_addr  unified-buffer read strobe / address
//   psum_in            array result (MATRIX_SIZE signed lanes)
//   res_we, res_addr,
//   res_data           result SRAM write port
//   busy               high in every state except IDLE
//   done               one-cycle completion pulse
//   state_dbg          current FSM state encoding (debug observation only)
//
// Handshake: start is a level that the block samples only in IDLE. busy rises
// in the cycle after an accepted start. It stays high until the cycle after
// the done pulse. A start seen while busy is ignored. abort wins over start in
// IDLE. In any other state abort returns the block to IDLE without a done
// pulse.
//
// All outputs are registered. A strobe is visible in the cycle after the
// clock edge that decided it.
// -----------------------------------------------------------------------------
module vec_mul_seq #(
  parameter int ADDRESSSIZE    = 10,
  parameter int MATRIX_SIZE    = 64,
  parameter int PARTIAL_SUM_BW = 24,
  parameter int PIPE_LATENCY   = 2,
  parameter int UB_RD_LATENCY  = 1
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic                                  load_weights,
  input  logic [ADDRESSSIZE-1:0]                vec_base,
  input  logic [ADDRESSSIZE-1:0]                res_base,
  input  logic [ADDRESSSIZE:0]                  vec_count,
  input  logic                                  fifo_empty,
  output logic                                  fifo_read_enable,
  output logic                                  weight_reload,
  output logic                                  ub_rd_en,
  output logic [ADDRESSSIZE-1:0]                ub_addr,
  input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] psum_in,
  output logic                                  res_we,
  output logic [ADDRESSSIZE-1:0]                res_addr,
  output logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] res_data,
  output logic                                  busy,
  output logic                                  done,
  output logic [2:0]                            state_dbg
);

  localparam int AW    = ADDRESSSIZE;
  localparam int CW    = ADDRESSSIZE + 1;
  localparam int LW    = PARTIAL_SUM_BW;
  localparam int DW    = PARTIAL_SUM_BW * MATRIX_SIZE;
  // Read strobe to qualified array result, in cycles.
  localparam int DEPTH = UB_RD_LATENCY + PIPE_LATENCY;

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WPOP   = 3'd1,
    S_WLATCH = 3'd2,
    S_STREAM = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t          state;
  logic [AW-1:0]   vec_base_q;
  logic [AW-1:0]   res_base_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   issue_idx;
  logic [CW-1:0]   wr_idx;
  // vpipe[DEPTH-1] marks the cycle in which psum_in carries a valid result.
  logic [DEPTH-1:0] vpipe;

  assign state_dbg = state;

  // Post-processing applied in the write-back register stage.
  function automatic logic [DW-1:0] post_proc(input logic [DW-1:0] d);
    logic [DW-1:0] r;
    r = d;
`ifdef VEC_MUL_SEQ_RELU_EN
    for (int i = 0; i < MATRIX_SIZE; i++) begin
      if (d[i*LW + LW - 1]) r[i*LW +: LW] = '0;
    end
`endif
    return r;
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= S_IDLE;
      vec_base_q       <= '0;
      res_base_q       <= '0;
      cnt_q            <= '0;
      issue_idx        <= '0;
      wr_idx           <= '0;
      vpipe            <= '0;
      fifo_read_enable <= 1'b0;
      weight_reload    <= 1'b0;
      ub_rd_en         <= 1'b0;
      ub_addr          <= '0;
      res_we           <= 1'b0;
      res_addr         <= '0;
      res_data         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      // Strobes default low; only the decisions below raise them.
      fifo_read_enable <= 1'b0;
      weight_reload    <= 1'b0;
      ub_rd_en         <= 1'b0;
      res_we           <= 1'b0;
      done             <= 1'b0;

      if (abort && state != S_IDLE) begin
        // A pop already on the bus completes. Nothing further is issued.
        state <= S_IDLE;
        busy  <= 1'b0;
        vpipe <= '0;
      end else begin
        vpipe <= {vpipe[DEPTH-2:0], ub_rd_en};

        // Write-back: the registered result lands one cycle after it is valid.
        if ((state == S_STREAM || state == S_DRAIN) && vpipe[DEPTH-1]) begin
          res_we   <= 1'b1;
          res_addr <= res_base_q + wr_idx[AW-1:0];
          res_data <= post_proc(psum_in);
          wr_idx   <= wr_idx + ONE;
        end

        case (state)
          S_IDLE: begin
            if (start && !abort) begin
              vec_base_q <= vec_base;
              res_base_q <= res_base;
              cnt_q      <= vec_count;
              wr_idx     <= '0;
              issue_idx  <= '0;
              busy       <= 1'b1;
              if (load_weights) begin
                state <= S_WPOP;
              end else if (vec_count != ZERO) begin
                // The first read issues on the launch edge. This keeps the
                // start-to-first-write latency at 1 + read + pipe + 1.
                ub_rd_en  <= 1'b1;
                ub_addr   <= vec_base;
                issue_idx <= ONE;
                state     <= (vec_count == ONE) ? S_DRAIN : S_STREAM;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end
          end

          S_WPOP: begin
            if (!fifo_empty) begin
              fifo_read_enable <= 1'b1;
              state            <= S_WLATCH;
            end
          end

          S_WLATCH: begin
            weight_reload <= 1'b1;
            if (cnt_q == ZERO) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_STREAM;
            end
          end

          S_STREAM: begin
            ub_rd_en  <= 1'b1;
            ub_addr   <= vec_base_q + issue_idx[AW-1:0];
            issue_idx <= issue_idx + ONE;
            if (issue_idx + ONE == cnt_q) state <= S_DRAIN;
          end

          S_DRAIN: begin
            // wr_idx reaching cnt_q means the final write is on the bus now.
            if (wr_idx == cnt_q) begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end

          S_DONE: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end

          default: begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_vec_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_vec_mul_seq
//
// Directed bench for vec_mul_seq with default parameters.
// Cycle numbering: start is driven during cycle 0 and sampled at the edge
// that ends cycle 0. Values are observed 1 ns after each edge. psum_in is
// re-driven every cycle with a pattern keyed to the cycle number, so the
// written data identifies the cycle it was captured in.
// -----------------------------------------------------------------------------
module tb_vec_mul_seq;

  localparam int AW = 10;
  localparam int MS = 64;
  localparam int PB = 24;
  localparam int DW = MS * PB;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic          load_weights;
  logic [AW-1:0] vec_base;
  logic [AW-1:0] res_base;
  logic [AW:0]   vec_count;
  logic          fifo_empty;
  logic          fifo_read_enable;
  logic          weight_reload;
  logic          ub_rd_en;
  logic [AW-1:0] ub_addr;
  logic [DW-1:0] psum_in;
  logic          res_we;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic          busy;
  logic          done;
  logic [2:0]    state_dbg;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  vec_mul_seq dut (
    .clk              (clk),
    .rstn             (rstn),
    .start            (start),
    .abort            (abort),
    .load_weights     (load_weights),
    .vec_base         (vec_base),
    .res_base         (res_base),
    .vec_count        (vec_count),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .weight_reload    (weight_reload),
    .ub_rd_en         (ub_rd_en),
    .ub_addr          (ub_addr),
    .psum_in          (psum_in),
    .res_we           (res_we),
    .res_addr         (res_addr),
    .res_data         (res_data),
    .busy             (busy),
    .done             (done),
    .state_dbg        (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] mk_psum(input int k);
    logic [DW-1:0] r;
    int lane;
    for (int i = 0; i < MS; i++) begin
      lane = k * 3 - 20 + i;
      r[i*PB +: PB] = lane[PB-1:0];
    end
    return r;
  endfunction

  // Expected write data for a result captured from pattern k.
  function automatic logic [DW-1:0] exp_data(input int k);
    logic [DW-1:0] r;
    int lane;
    for (int i = 0; i < MS; i++) begin
      lane = k * 3 - 20 + i;
`ifdef VEC_MUL_SEQ_RELU_EN
      if (lane < 0) lane = 0;
`endif
      r[i*PB +: PB] = lane[PB-1:0];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    psum_in = mk_psum(cyc);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input int k);
    logic [DW-1:0] e;
    int bad;
    e = exp_data(k);
    bad = -1;
    for (int i = MS - 1; i >= 0; i--) if (res_data[i*PB +: PB] !== e[i*PB +: PB]) bad = i;
    checks++;
    assert (res_data === e) else begin
      failures++;
      $error("FAIL %s lane=%0d observed=%h expected=%h", tag, bad,
             (bad >= 0) ? res_data[bad*PB +: PB] : '0, (bad >= 0) ? e[bad*PB +: PB] : '0);
    end
  endtask

  // Launch a job without weight load and check every cycle until one past done.
  task automatic run_job(input string tag, input int vb, input int rb, input int cnt);
    int last;
    bit en, we;
    vec_base     = vb[AW-1:0];
    res_base     = rb[AW-1:0];
    vec_count    = cnt[AW:0];
    load_weights = 1'b0;
    start        = 1'b1;
    cyc          = 0;
    psum_in      = mk_psum(0);
    last = (cnt == 0) ? 1 : cnt + 5;
    for (int c = 1; c <= last + 1; c++) begin
      tick();
      start = 1'b0;
      en = (c <= cnt);
      we = (cnt > 0) && (c >= 5) && (c <= cnt + 4);
      check($sformatf("%s.ub_rd_en@%0d", tag, c), ub_rd_en, en);
      if (en) check($sformatf("%s.ub_addr@%0d", tag, c), ub_addr, (vb + c - 1) % 1024);
      check($sformatf("%s.res_we@%0d", tag, c), res_we, we);
      if (we) begin
        check($sformatf("%s.res_addr@%0d", tag, c), res_addr, (rb + c - 5) % 1024);
        check_data($sformatf("%s.res_data@%0d", tag, c), c - 1);
      end
      check($sformatf("%s.done@%0d", tag, c), done, (c == last));
      check($sformatf("%s.busy@%0d", tag, c), busy, (c <= last));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [PB-1:0] m7;
    m7 = -24'sd7;
    rstn = 1'b0; start = 1'b0; abort = 1'b0; load_weights = 1'b0;
    vec_base = '0; res_base = '0; vec_count = '0; fifo_empty = 1'b1;
    psum_in = mk_psum(0);

    // Reset state.
    repeat (3) tick();
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.ub_rd_en", ub_rd_en, 0);
    check("rst.res_we", res_we, 0);
    check("rst.fifo_read_enable", fifo_read_enable, 0);
    check("rst.weight_reload", weight_reload, 0);
    check("rst.state", state_dbg, 0);
    check("rst.res_addr", res_addr, 0);
    rstn = 1'b1;
    repeat (2) tick();

    // Basic 4-vector job.
    run_job("basic", 5, 100, 4);

    // Address wrap on both counters.
    run_job("wrap", 1022, 1023, 3);

    // Empty job.
    run_job("zero", 0, 0, 0);

    // Weight load with FIFO stall; a second start during WPOP must be ignored.
    vec_base = 10'd3; res_base = 10'd9; vec_count = 11'd2;
    load_weights = 1'b1; fifo_empty = 1'b1; start = 1'b1; cyc = 0;
    psum_in = mk_psum(0);
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c == 2) begin
        start = 1'b1;
        vec_count = 11'd5;
      end else begin
        start = 1'b0;
      end
      if (c == 4) fifo_empty = 1'b0;
      check($sformatf("wload.fifo_read_enable@%0d", c), fifo_read_enable, (c == 5));
      check($sformatf("wload.weight_reload@%0d", c), weight_reload, (c == 6));
      check($sformatf("wload.ub_rd_en@%0d", c), ub_rd_en, (c == 7 || c == 8));
      if (c == 7 || c == 8) check($sformatf("wload.ub_addr@%0d", c), ub_addr, 3 + c - 7);
      check($sformatf("wload.res_we@%0d", c), res_we, (c == 11 || c == 12));
      if (c == 11 || c == 12) begin
        check($sformatf("wload.res_addr@%0d", c), res_addr, 9 + c - 11);
        check_data($sformatf("wload.res_data@%0d", c), c - 1);
      end
      check($sformatf("wload.done@%0d", c), done, (c == 13));
      check($sformatf("wload.busy@%0d", c), busy, (c <= 13));
    end
    fifo_empty = 1'b1;
    load_weights = 1'b0;

    // Start and abort together in IDLE: abort wins.
    vec_count = 11'd4; start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("idle_abort.busy", busy, 0);
    check("idle_abort.ub_rd_en", ub_rd_en, 0);
    tick();
    check("idle_abort.busy2", busy, 0);
    check("idle_abort.state", state_dbg, 0);

    // Abort two cycles into an 8-vector stream, then restart at once.
    vec_base = '0; res_base = '0; vec_count = 11'd8; start = 1'b1; cyc = 0;
    tick();
    start = 1'b0;
    check("abort.busy@1", busy, 1);
    check("abort.ub_rd_en@1", ub_rd_en, 1);
    tick();
    abort = 1'b1;
    check("abort.ub_rd_en@2", ub_rd_en, 1);
    tick();
    abort = 1'b0;
    check("abort.busy@3", busy, 0);
    check("abort.ub_rd_en@3", ub_rd_en, 0);
    check("abort.done@3", done, 0);
    check("abort.state@3", state_dbg, 0);
    // Any leftover write from the aborted job would land inside this window.
    run_job("restart", 50, 600, 1);

    // Lane post-processing with hand values -7, 0, 12.
    vec_base = '0; res_base = 10'd7; vec_count = 11'd1; start = 1'b1; cyc = 0;
    psum_in = mk_psum(0);
    tick(); start = 1'b0;
    tick();
    tick();
    tick();
    psum_in[0*PB +: PB] = m7;
    psum_in[1*PB +: PB] = 24'd0;
    psum_in[2*PB +: PB] = 24'd12;
    tick();
    check("relu.res_we", res_we, 1);
    check("relu.res_addr", res_addr, 7);
`ifdef VEC_MUL_SEQ_RELU_EN
    check("relu.lane0", res_data[0*PB +: PB], 0);
`else
    check("relu.lane0", res_data[0*PB +: PB], m7);
`endif
    check("relu.lane1", res_data[1*PB +: PB], 0);
    check("relu.lane2", res_data[2*PB +: PB], 12);
    tick();
    check("relu.done", done, 1);
    tick();
    check("relu.busy_end", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
